lc3_mem_arbiter: RTL and testbench

Shares the LC3's single memory port between two requesters: port 0 (LC3 core MAR/MDR side) and port 1 (program loader / DMA).
- Sequences each access with a configurable fixed memory latency.
- Returns read data and a one-cycle acknowledge to the winning requester.
- Sits between the core/loader and the synchronous memory model.

---
 rtl/lc3_mem_arbiter.sv | 92 +++++++++
 tb/tb_lc3_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_mem_arbiter.sv
// lc3_mem_arbiter: shares the single LC3 memory port between the core (port 0) and the loader (port 1),
// sequencing each access with a fixed MEM_LAT read/write latency.
module lc3_mem_arbiter #(
   parameter int MEM_LAT       = 1,
   parameter int PRIORITY_MODE = 0,
   parameter int ADDR_W        = 16,
   parameter int DATA_W        = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_ack,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_ack,
   output logic [DATA_W-1:0] p1_rdata,
   output logic [1:0]        grant,
   output logic              busy,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   state_t     state, state_nx;
   logic [3:0] cnt;
   logic       last_grant;
   logic       we_r;
   logic       sel1;
   logic       start;
   if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_lat_check
      $error("lc3_mem_arbiter: MEM_LAT must be in 1..15");
   end
   assign start = p0_req | p1_req;
   // port 1 wins when alone, or on a round-robin tie when port 0 was served last
   assign sel1 = p1_req & (~p0_req | (PRIORITY_MODE == 0 && !last_grant));
   always_comb begin
      state_nx = IDLE;
      busy = 1'b0;
      mem_en = 1'b0;
      mem_we = 1'b0;
      p0_ack = 1'b0;
      p1_ack = 1'b0;
      state_nx = state == IDLE  ? (start ? ISSUE : IDLE)
               : state == ISSUE ? WAIT
               : state == WAIT  ? (cnt == 4'd0 ? DONE : WAIT)
               : IDLE;
      busy = state != IDLE;
      mem_en = state == ISSUE;
      mem_we = mem_en & we_r;
      p0_ack = state == DONE && grant[0];
      p1_ack = state == DONE && grant[1];
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         grant <= 2'b00;
         last_grant <= 1'b1;
         we_r <= 1'b0;
         mem_addr <= '0;
         mem_wdata <= '0;
         cnt <= 4'd0;
         p0_rdata <= '0;
         p1_rdata <= '0;
      end else begin
         if (state == IDLE && start) begin
            grant <= {sel1, ~sel1};
            last_grant <= sel1;
            we_r <= sel1 ? p1_we : p0_we;
            mem_addr <= sel1 ? p1_addr : p0_addr;
            mem_wdata <= sel1 ? p1_wdata : p0_wdata;
         end
         if (state == ISSUE) cnt <= 4'(MEM_LAT - 1);
         if (state == WAIT) cnt <= cnt - 4'd1;
         // the last WAIT cycle is exactly MEM_LAT cycles after mem_en
         if (state == WAIT && cnt == 4'd0 && !we_r) begin
            if (grant[0]) p0_rdata <= mem_rdata;
            if (grant[1]) p1_rdata <= mem_rdata;
         end
         if (state == DONE) grant <= 2'b00;
      end
   end
endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// tb_lc3_mem_arbiter: directed and randomized checks of lc3_mem_arbiter (round-robin and fixed-priority
// instances) against a transaction-level model of arbitration, latency and memory contents.
module tb_lc3_mem_arbiter;
   localparam int L = 3;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic p0_req, p0_we, p1_req, p1_we;
   logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
   logic p0_ack [2], p1_ack [2], mem_en [2], mem_we [2], busy [2];
   logic [1:0] grant [2];
   logic [15:0] p0_rdata [2], p1_rdata [2], mem_addr [2], mem_wdata [2], mem_rdata [2];
   logic [15:0] mem [2][65536];
   logic [15:0] ref_mem [65536];
   int checks = 0, failures = 0;
   int cyc = 0;
   int due [2] = '{-100, -100};
   logic [15:0] due_addr [2];
   int en_cnt [2] = '{0, 0};
   logic last_we [2];
   logic [15:0] last_addr [2], last_wdata [2];
   logic cur_we [2];
   logic [15:0] cur_addr [2], cur_wdata [2];

   for (genvar k = 0; k < 2; k++) begin : g_dut
      lc3_mem_arbiter #(.MEM_LAT(L), .PRIORITY_MODE(k), .ADDR_W(16), .DATA_W(16)) u_dut (
         .clk(clk), .reset(reset),
         .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
         .p0_ack(p0_ack[k]), .p0_rdata(p0_rdata[k]),
         .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
         .p1_ack(p1_ack[k]), .p1_rdata(p1_rdata[k]),
         .grant(grant[k]), .busy(busy[k]), .mem_en(mem_en[k]), .mem_we(mem_we[k]),
         .mem_addr(mem_addr[k]), .mem_wdata(mem_wdata[k]), .mem_rdata(mem_rdata[k])
      );
   end

   always #5 clk = ~clk;

   // memory: data is valid only in the cycle exactly L after mem_en, garbage otherwise
   always @(negedge clk) begin
      cyc = cyc + 1;
      for (int k = 0; k < 2; k++) begin
         mem_rdata[k] = (cyc == due[k]) ? mem[k][due_addr[k]] : 16'($urandom);
         if (mem_en[k] === 1'b1) begin
            en_cnt[k]++;
            last_we[k] = mem_we[k];
            last_addr[k] = mem_addr[k];
            last_wdata[k] = mem_wdata[k];
            if (mem_we[k] === 1'b1) mem[k][mem_addr[k]] = mem_wdata[k];
            due[k] = cyc + L;
            due_addr[k] = mem_addr[k];
         end
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [15:0] a, input logic [15:0] d);
      mem[0][a] = d;
      mem[1][a] = d;
      ref_mem[a] = d;
   endtask

   task automatic do_reset;
      reset = 1'b0;
      p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
      p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
      step;
      step;
      reset = 1'b1;
   endtask

   task automatic wait_ack(input int k, input int p, output int n);
      n = -1;
      for (int i = 1; i <= 40; i++) begin
         step;
         if ((p == 0 ? p0_ack[k] : p1_ack[k]) === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic test_reset;
      int n;
      reset = 1'b0;
      p0_req = 1; p0_we = 0; p0_addr = 16'h1111; p0_wdata = 0;
      p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
      step;
      step;
      checks++; if (grant[0] !== 2'b00) begin failures++; $display("FAIL rst_grant got=%b want=00", grant[0]); end
      checks++; if (grant[1] !== 2'b00) begin failures++; $display("FAIL rst_grant_fp got=%b want=00", grant[1]); end
      checks++; if (mem_en[0] !== 1'b0) begin failures++; $display("FAIL rst_mem_en got=%b want=0", mem_en[0]); end
      checks++; if (p0_ack[0] !== 1'b0) begin failures++; $display("FAIL rst_ack got=%b want=0", p0_ack[0]); end
      checks++; if (p0_rdata[0] !== 16'h0) begin failures++; $display("FAIL rst_rdata got=%h want=0000", p0_rdata[0]); end
      checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b want=0", busy[0]); end
      reset = 1'b1;
      step;
      checks++; if (mem_en[0] !== 1'b1 || mem_addr[0] !== 16'h1111) begin failures++; $display("FAIL rst_first_issue got en=%b addr=%h want en=1 addr=1111", mem_en[0], mem_addr[0]); end
      wait_ack(0, 0, n);
      checks++; if (n !== L + 1) begin failures++; $display("FAIL rst_first_ack got=%0d want=%0d", n, L + 1); end
      checks++; if (p0_rdata[0] !== ref_mem[16'h1111]) begin failures++; $display("FAIL rst_first_rdata got=%h want=%h", p0_rdata[0], ref_mem[16'h1111]); end
      p0_req = 0;
   endtask

   task automatic test_single_read;
      int n;
      do_reset;
      preload(16'h3000, 16'h1234);
      p0_we = 0; p0_addr = 16'h3000; p0_req = 1;
      wait_ack(0, 0, n);
      checks++; if (n !== L + 2) begin failures++; $display("FAIL rd_latency got=%0d want=%0d", n, L + 2); end
      checks++; if (p0_rdata[0] !== 16'h1234) begin failures++; $display("FAIL rd_data got=%h want=1234", p0_rdata[0]); end
      p0_req = 0;
      step;
      checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL rd_busy_after got=%b want=0", busy[0]); end
   endtask

   task automatic test_single_write;
      int n, e0;
      do_reset;
      preload(16'h4000, 16'h7777);
      p1_we = 0; p1_addr = 16'h4000; p1_req = 1;
      wait_ack(0, 1, n);
      checks++; if (p1_rdata[0] !== 16'h7777) begin failures++; $display("FAIL wr_pre_read got=%h want=7777", p1_rdata[0]); end
      p1_req = 0;
      step;
      e0 = en_cnt[0];
      p1_we = 1; p1_addr = 16'h4000; p1_wdata = 16'hBEEF; p1_req = 1;
      wait_ack(0, 1, n);
      ref_mem[16'h4000] = 16'hBEEF;
      checks++; if (n !== L + 2) begin failures++; $display("FAIL wr_latency got=%0d want=%0d", n, L + 2); end
      checks++; if (en_cnt[0] - e0 !== 1) begin failures++; $display("FAIL wr_en_count got=%0d want=1", en_cnt[0] - e0); end
      checks++; if (last_we[0] !== 1'b1 || last_addr[0] !== 16'h4000 || last_wdata[0] !== 16'hBEEF) begin failures++; $display("FAIL wr_bus got we=%b addr=%h wdata=%h want we=1 addr=4000 wdata=beef", last_we[0], last_addr[0], last_wdata[0]); end
      checks++; if (mem[0][16'h4000] !== 16'hBEEF) begin failures++; $display("FAIL wr_mem got=%h want=beef", mem[0][16'h4000]); end
      checks++; if (p1_rdata[0] !== 16'h7777) begin failures++; $display("FAIL wr_rdata_kept got=%h want=7777", p1_rdata[0]); end
      p1_req = 0;
      p1_we = 0;
   endtask

   task automatic test_round_robin;
      int order[$];
      int at[$];
      do_reset;
      p0_we = 0; p0_addr = 16'h3001; p1_we = 0; p1_addr = 16'h3002;
      p0_req = 1; p1_req = 1;
      for (int i = 1; i <= 40 && order.size() < 4; i++) begin
         step;
         checks++; if (p0_ack[0] === 1'b1 && p1_ack[0] === 1'b1) begin failures++; $display("FAIL rr_overlap got both acks at step %0d want one", i); end
         if (p0_ack[0] === 1'b1) begin order.push_back(0); at.push_back(i); end
         if (p1_ack[0] === 1'b1) begin order.push_back(1); at.push_back(i); end
      end
      checks++; if (order.size() != 4) begin failures++; $display("FAIL rr_count got=%0d want=4", order.size()); end
      if (order.size() > 0) begin
         checks++; if (at[0] != L + 2) begin failures++; $display("FAIL rr_first got=%0d want=%0d", at[0], L + 2); end
      end
      for (int i = 0; i < order.size(); i++) begin
         checks++; if (order[i] != i % 2) begin failures++; $display("FAIL rr_order[%0d] got=p%0d want=p%0d", i, order[i], i % 2); end
         if (i > 0) begin
            checks++; if (at[i] - at[i-1] != L + 3) begin failures++; $display("FAIL rr_spacing[%0d] got=%0d want=%0d", i, at[i] - at[i-1], L + 3); end
         end
      end
      p0_req = 0; p1_req = 0;
   endtask

   task automatic test_fixed_priority;
      int a0 = 0, a1 = 0, n;
      do_reset;
      preload(16'h3004, 16'hC0DE);
      p0_we = 0; p0_addr = 16'h3003; p1_we = 0; p1_addr = 16'h3004;
      p0_req = 1; p1_req = 1;
      for (int i = 0; i < 4 * (L + 3); i++) begin
         step;
         if (p0_ack[1] === 1'b1) a0++;
         if (p1_ack[1] === 1'b1) a1++;
      end
      checks++; if (a0 != 4) begin failures++; $display("FAIL fp_p0_acks got=%0d want=4", a0); end
      checks++; if (a1 != 0) begin failures++; $display("FAIL fp_p1_starved got=%0d want=0", a1); end
      wait_ack(1, 0, n);
      checks++; if (n != L + 2) begin failures++; $display("FAIL fp_p0_next got=%0d want=%0d", n, L + 2); end
      p0_req = 0;
      wait_ack(1, 1, n);
      checks++; if (n != L + 3) begin failures++; $display("FAIL fp_p1_served got=%0d want=%0d", n, L + 3); end
      checks++; if (p1_rdata[1] !== 16'hC0DE) begin failures++; $display("FAIL fp_p1_rdata got=%h want=c0de", p1_rdata[1]); end
      p1_req = 0;
   endtask

   task automatic test_abort;
      int n, a0 = 0, hit = -1;
      do_reset;
      p0_we = 0; p0_addr = 16'h2222; p0_req = 1;
      step;
      step;
      p0_req = 0;
      wait_ack(0, 0, n);
      checks++; if (n != L) begin failures++; $display("FAIL ab_drop_ack got=%0d want=%0d", n, L); end
      checks++; if (p0_rdata[0] !== ref_mem[16'h2222]) begin failures++; $display("FAIL ab_drop_rdata got=%h want=%h", p0_rdata[0], ref_mem[16'h2222]); end
      step;
      p0_addr = 16'h2468; p0_req = 1;
      step;
      step;
      reset = 1'b0;
      #1;
      checks++; if (grant[0] !== 2'b00 || busy[0] !== 1'b0 || mem_en[0] !== 1'b0 || p0_ack[0] !== 1'b0) begin failures++; $display("FAIL ab_reset_outs got grant=%b busy=%b en=%b ack=%b want 00 0 0 0", grant[0], busy[0], mem_en[0], p0_ack[0]); end
      checks++; if (p0_rdata[0] !== 16'h0) begin failures++; $display("FAIL ab_reset_rdata got=%h want=0000", p0_rdata[0]); end
      step;
      p0_req = 0;
      p1_we = 0; p1_addr = 16'h1357; p1_req = 1;
      reset = 1'b1;
      for (int i = 1; i <= L + 4; i++) begin
         step;
         if (p0_ack[0] === 1'b1) a0++;
         if (p1_ack[0] === 1'b1 && hit < 0) hit = i;
      end
      checks++; if (a0 != 0) begin failures++; $display("FAIL ab_no_ack got=%0d want=0", a0); end
      checks++; if (hit != L + 2) begin failures++; $display("FAIL ab_p1_ack got=%0d want=%0d", hit, L + 2); end
      checks++; if (p1_rdata[0] !== ref_mem[16'h1357]) begin failures++; $display("FAIL ab_p1_rdata got=%h want=%h", p1_rdata[0], ref_mem[16'h1357]); end
      p1_req = 0;
   endtask

   task automatic drive(input int p, input int ntx);
      #1;
      for (int t = 0; t < ntx; t++) begin
         int g = $urandom_range(0, 3);
         repeat (g) begin @(posedge clk); #2; end
         cur_we[p] = 1'($urandom_range(0, 1));
         cur_addr[p] = 16'h3000 + 16'($urandom_range(0, 7));
         cur_wdata[p] = 16'($urandom);
         if (p == 0) begin p0_we = cur_we[0]; p0_addr = cur_addr[0]; p0_wdata = cur_wdata[0]; p0_req = 1; end
         else begin p1_we = cur_we[1]; p1_addr = cur_addr[1]; p1_wdata = cur_wdata[1]; p1_req = 1; end
         for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #2;
            if ((p == 0 ? p0_ack[0] : p1_ack[0]) === 1'b1) break;
         end
         if (p == 0) p0_req = 0;
         else p1_req = 0;
      end
   endtask

   task automatic test_random;
      int done0 = 0, done1 = 0, owner = -1, el = 0, acks = 0;
      logic lg = 1'b1;
      do_reset;
      fork
         begin drive(0, 12); done0 = 1; end
         begin drive(1, 12); done1 = 1; end
         for (int c = 0; c < 3000 && !(done0 == 1 && done1 == 1); c++) begin
            step;
            checks++; if (p0_ack[0] === 1'b1 && p1_ack[0] === 1'b1) begin failures++; $display("FAIL rnd_overlap got both acks want one"); end
            if (owner < 0 && grant[0] !== 2'b00) begin
               int w = (p0_req && p1_req) ? (lg ? 0 : 1) : (p1_req ? 1 : 0);
               checks++; if (grant[0] !== (w == 1 ? 2'b10 : 2'b01)) begin failures++; $display("FAIL rnd_grant got=%b want=p%0d", grant[0], w); end
               checks++; if (mem_en[0] !== 1'b1 || mem_addr[0] !== cur_addr[w] || mem_we[0] !== cur_we[w] || (cur_we[w] && mem_wdata[0] !== cur_wdata[w])) begin failures++; $display("FAIL rnd_issue got en=%b we=%b addr=%h wd=%h want en=1 we=%b addr=%h wd=%h", mem_en[0], mem_we[0], mem_addr[0], mem_wdata[0], cur_we[w], cur_addr[w], cur_wdata[w]); end
               lg = (w == 1);
               owner = w;
               el = 0;
            end else if (owner >= 0) el++;
            if (p0_ack[0] === 1'b1 || p1_ack[0] === 1'b1) begin
               int p = (p1_ack[0] === 1'b1) ? 1 : 0;
               acks++;
               checks++; if (p != owner || el != L + 1) begin failures++; $display("FAIL rnd_ack got port=%0d after=%0d want port=%0d after=%0d", p, el, owner, L + 1); end
               if (cur_we[p]) ref_mem[cur_addr[p]] = cur_wdata[p];
               else begin
                  checks++; if ((p == 1 ? p1_rdata[0] : p0_rdata[0]) !== ref_mem[cur_addr[p]]) begin failures++; $display("FAIL rnd_rdata got=%h want=%h", (p == 1 ? p1_rdata[0] : p0_rdata[0]), ref_mem[cur_addr[p]]); end
               end
               owner = -1;
            end else if (owner >= 0 && el > L + 1) begin
               checks++; failures++; $display("FAIL rnd_timeout got no ack after=%0d want ack at %0d", el, L + 1);
               owner = -1;
            end
         end
      join
      checks++; if (acks != 24) begin failures++; $display("FAIL rnd_total got=%0d want=24", acks); end
   endtask

   initial begin
      for (int a = 0; a < 65536; a++) begin
         mem[0][a] = 16'(a) ^ 16'h5A5A;
         mem[1][a] = 16'(a) ^ 16'h5A5A;
         ref_mem[a] = 16'(a) ^ 16'h5A5A;
      end
      test_reset;
      test_single_read;
      test_single_write;
      test_round_robin;
      test_fixed_priority;
      test_abort;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
